// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and channel FSM state encodings.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

endpackage

// File: rtl/dmem_ram.sv
// Word RAM with byte-enabled synchronous write and registered read-first read port.
module dmem_ram #(
  parameter int unsigned MEM_WORDS = 512,
  parameter int unsigned AW        = $clog2(MEM_WORDS),
  parameter string       INIT_FILE = ""
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [MEM_WORDS];
  logic [31:0] r_rdata;

  // Read and write share one process so a same-word collision returns the old word.
  always_ff @(posedge i_clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_lite_dmem.sv
// AXI4-Lite slave data memory: independent write and read channels, one outstanding each.
module axi_lite_dmem
  import axi_lite_pkg::*;
#(
  parameter int unsigned AXI_AWIDTH = 12,
  parameter int unsigned AXI_DWIDTH = 32,
  parameter int unsigned MEM_WORDS  = 512,
  parameter string       INIT_FILE  = ""
) (
  input  logic                    CLK,
  input  logic                    NRST,
  input  logic [AXI_AWIDTH-1:0]   AXI_AWADDR,
  input  logic                    AXI_AWVALID,
  output logic                    AXI_AWREADY,
  input  logic [AXI_DWIDTH-1:0]   AXI_WDATA,
  input  logic [AXI_DWIDTH/8-1:0] AXI_WSTRB,
  input  logic                    AXI_WVALID,
  output logic                    AXI_WREADY,
  output logic [1:0]              AXI_BRESP,
  output logic                    AXI_BVALID,
  input  logic                    AXI_BREADY,
  input  logic [AXI_AWIDTH-1:0]   AXI_ARADDR,
  input  logic                    AXI_ARVALID,
  output logic                    AXI_ARREADY,
  output logic [AXI_DWIDTH-1:0]   AXI_RDATA,
  output logic [1:0]              AXI_RRESP,
  output logic                    AXI_RVALID,
  input  logic                    AXI_RREADY
);

  localparam int unsigned IW     = AXI_AWIDTH - 2;
  localparam int unsigned RAM_AW = $clog2(MEM_WORDS);

  // Byte offset within the word never affects the access.
  logic w_unused_addr_lsbs;
  assign w_unused_addr_lsbs = ^{AXI_AWADDR[1:0], AXI_ARADDR[1:0]};

  // ---------------- write channel ----------------
  w_state_e                r_wstate, w_wstate_d;
  logic                    r_aw_cap, w_aw_cap_d;
  logic                    r_w_cap, w_w_cap_d;
  logic [IW-1:0]           r_aw_idx, w_aw_idx_d;
  logic [AXI_DWIDTH-1:0]   r_wdata, w_wdata_d;
  logic [AXI_DWIDTH/8-1:0] r_wstrb, w_wstrb_d;
  logic                    r_awready, w_awready_d;
  logic                    r_wready, w_wready_d;
  logic                    r_bvalid, w_bvalid_d;
  logic [1:0]              r_bresp, w_bresp_d;
  logic                    w_aw_hs, w_w_hs, w_do_write, w_aw_in_range, w_ram_we;

  assign w_aw_hs       = AXI_AWVALID & r_awready;
  assign w_w_hs        = AXI_WVALID & r_wready;
  assign w_aw_in_range = 32'(r_aw_idx) < MEM_WORDS;
  assign w_do_write    = (r_wstate == W_IDLE) & r_aw_cap & r_w_cap;
  assign w_ram_we      = w_do_write & w_aw_in_range;

  always_comb begin
    w_wstate_d = r_wstate;
    w_aw_cap_d = r_aw_cap;
    w_w_cap_d  = r_w_cap;
    w_aw_idx_d = r_aw_idx;
    w_wdata_d  = r_wdata;
    w_wstrb_d  = r_wstrb;
    w_bvalid_d = r_bvalid;
    w_bresp_d  = r_bresp;
    unique case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs) begin
          w_aw_cap_d = 1'b1;
          w_aw_idx_d = AXI_AWADDR[AXI_AWIDTH-1:2];
        end
        if (w_w_hs) begin
          w_w_cap_d = 1'b1;
          w_wdata_d = AXI_WDATA;
          w_wstrb_d = AXI_WSTRB;
        end
        if (w_do_write) begin
          w_wstate_d = W_RESP;
          w_bvalid_d = 1'b1;
          w_bresp_d  = w_aw_in_range ? RESP_OKAY : RESP_SLVERR;
        end
      end
      W_RESP: begin
        if (AXI_BREADY) begin
          w_wstate_d = W_IDLE;
          w_bvalid_d = 1'b0;
          w_aw_cap_d = 1'b0;
          w_w_cap_d  = 1'b0;
        end
      end
      default: w_wstate_d = W_IDLE;
    endcase
    w_awready_d = (w_wstate_d == W_IDLE) & ~w_aw_cap_d;
    w_wready_d  = (w_wstate_d == W_IDLE) & ~w_w_cap_d;
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_wstate  <= W_IDLE;
      r_aw_cap  <= 1'b0;
      r_w_cap   <= 1'b0;
      r_aw_idx  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_wstate  <= w_wstate_d;
      r_aw_cap  <= w_aw_cap_d;
      r_w_cap   <= w_w_cap_d;
      r_aw_idx  <= w_aw_idx_d;
      r_wdata   <= w_wdata_d;
      r_wstrb   <= w_wstrb_d;
      r_awready <= w_awready_d;
      r_wready  <= w_wready_d;
      r_bvalid  <= w_bvalid_d;
      r_bresp   <= w_bresp_d;
    end
  end

  // ---------------- read channel ----------------
  r_state_e      r_rstate, w_rstate_d;
  logic          r_arready, w_arready_d;
  logic          r_rvalid, w_rvalid_d;
  logic [1:0]    r_rresp, w_rresp_d;
  logic [IW-1:0] w_ar_idx;
  logic          w_ar_hs, w_ar_in_range;
  logic [31:0]   w_ram_rdata;

  assign w_ar_idx      = AXI_ARADDR[AXI_AWIDTH-1:2];
  assign w_ar_hs       = AXI_ARVALID & r_arready;
  assign w_ar_in_range = 32'(w_ar_idx) < MEM_WORDS;

  always_comb begin
    w_rstate_d = r_rstate;
    w_rvalid_d = r_rvalid;
    w_rresp_d  = r_rresp;
    unique case (r_rstate)
      R_IDLE: begin
        if (w_ar_hs) begin
          w_rstate_d = R_DATA;
          w_rvalid_d = 1'b1;
          w_rresp_d  = w_ar_in_range ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_DATA: begin
        if (AXI_RREADY) begin
          w_rstate_d = R_IDLE;
          w_rvalid_d = 1'b0;
        end
      end
      default: w_rstate_d = R_IDLE;
    endcase
    w_arready_d = (w_rstate_d == R_IDLE);
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_rstate  <= w_rstate_d;
      r_arready <= w_arready_d;
      r_rvalid  <= w_rvalid_d;
      r_rresp   <= w_rresp_d;
    end
  end

  // RAM read register only loads on an in-range handshake, so it holds while stalled.
  dmem_ram #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (RAM_AW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .i_clk   (CLK),
    .i_we    (w_ram_we),
    .i_be    (r_wstrb),
    .i_waddr (r_aw_idx[RAM_AW-1:0]),
    .i_wdata (r_wdata),
    .i_re    (w_ar_hs & w_ar_in_range),
    .i_raddr (w_ar_idx[RAM_AW-1:0]),
    .o_rdata (w_ram_rdata)
  );

  assign AXI_AWREADY = r_awready;
  assign AXI_WREADY  = r_wready;
  assign AXI_BVALID  = r_bvalid;
  assign AXI_BRESP   = r_bresp;
  assign AXI_ARREADY = r_arready;
  assign AXI_RVALID  = r_rvalid;
  assign AXI_RRESP   = r_rresp;
  assign AXI_RDATA   = (r_rvalid && r_rresp == RESP_OKAY) ? w_ram_rdata : '0;

endmodule
